// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of ro_in
// over a fixed window of GATE_CYCLES clk cycles, optionally re-arming forever.
module ro_freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int WIN_W = $clog2(GATE_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [1:0]       r_state;
  logic             r_arm_cnt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf_int;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_edge;
  logic             w_sat;
  logic             w_last;
  logic [CNT_W-1:0] w_edge_next;
  logic             w_ovf_next;

  // sync2 & ~sync3 yields at most one event per clk cycle
  assign w_edge      = r_sync2 & ~r_sync3;
  assign w_sat       = (r_edge_cnt == CNT_MAX);
  assign w_last      = (r_win_cnt == '0);
  assign w_edge_next = (w_edge && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_next  = r_ovf_int | (w_edge & w_sat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ro_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_arm_cnt  <= 1'b0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_ovf_int  <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ARM;
            r_arm_cnt <= 1'b0;
          end
        end
        S_ARM: begin
          // two ARM cycles let stale synchronizer history drain before GATE
          r_edge_cnt <= '0;
          r_ovf_int  <= 1'b0;
          r_win_cnt  <= WIN_LOAD;
          r_arm_cnt  <= 1'b1;
          if (r_arm_cnt) begin
            r_state <= S_GATE;
          end
        end
        S_GATE: begin
          r_edge_cnt <= w_edge_next;
          r_ovf_int  <= w_ovf_next;
          r_win_cnt  <= r_win_cnt - WIN_W'(1);
          if (w_last) begin
            r_count <= w_edge_next;
            r_ovf   <= w_ovf_next;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (cont) begin
            r_state   <= S_ARM;
            r_arm_cnt <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: expected results are queued at start time
// and checked (cycle, count range, ovf) when each done pulse appears.
module tb_ro_freq_meter;

  localparam int GATE = 1024;

  typedef struct {
    int   cyc;
    int   lo;
    int   hi;
    logic ov;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ro_in;
  logic        start;
  logic        cont;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic        ovf;

  logic        start8;
  logic        cont8;
  logic        busy8;
  logic        done8;
  logic [7:0]  count8;
  logic        ovf8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ro_half = 0;
  logic ro_hold = 1'b0;
  int   ro_ph = 0;
  exp_t q_main[$];
  exp_t q8[$];
  exp_t em;
  exp_t e8;

  ro_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .cont(cont),
    .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  ro_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start8), .cont(cont8),
    .busy(busy8), .done(done8), .count(count8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ro_in source: toggles every ro_half cycles, or holds ro_hold when ro_half==0
  initial begin
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        ro_in = ro_hold;
        ro_ph = 0;
      end else begin
        ro_ph = ro_ph + 1;
        if (ro_ph >= ro_half) begin
          ro_ph = 0;
          ro_in = ~ro_in;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      checks++;
      assert (q_main.size() !== 0) else begin
        errors++;
        $error("FAIL main_unexpected_done cyc=%0d expected no done", cyc);
      end
      if (q_main.size() != 0) begin
        em = q_main.pop_front();
        chk("main_done_cycle", cyc, em.cyc);
        chk_range("main_count", int'(count), em.lo, em.hi);
        chk("main_ovf", {31'd0, ovf}, {31'd0, em.ov});
        $display("main done cyc=%0d count=%0d ovf=%0d", cyc, count, ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      checks++;
      assert (q8.size() !== 0) else begin
        errors++;
        $error("FAIL w8_unexpected_done cyc=%0d expected no done", cyc);
      end
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("w8_done_cycle", cyc, e8.cyc);
        chk_range("w8_count", int'(count8), e8.lo, e8.hi);
        chk("w8_ovf", {31'd0, ovf8}, {31'd0, e8.ov});
        $display("w8 done cyc=%0d count=%0d ovf=%0d", cyc, count8, ovf8);
      end
    end
  end

  task automatic pulse_start(input int lo, input int hi, input logic ov);
    @(negedge clk);
    start = 1'b1;
    q_main.push_back('{cyc + GATE + 3, lo, hi, ov});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_main(input int budget, input string tag);
    for (int i = 0; i < budget && q_main.size() != 0; i++) @(negedge clk);
    checks++;
    assert (q_main.size() === 0) else begin
      errors++;
      $error("FAIL %s pending=%0d expected 0", tag, q_main.size());
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; cont = 1'b0; start8 = 1'b0; cont8 = 1'b0;
    ro_half = 4;
    repeat (4) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);

    // period 8, start in the very first cycle after reset release
    rst = 1'b0;
    start = 1'b1;
    q_main.push_back('{cyc + GATE + 3, 127, 128, 1'b0});
    @(negedge clk);
    start = 1'b0;
    chk("arm_busy", {31'd0, busy}, 32'd1);
    wait_main(GATE + 20, "p8_timeout");
    @(negedge clk);
    chk("p8_idle_busy", {31'd0, busy}, 32'd0);

    // ro_in held low, then held high
    ro_half = 0; ro_hold = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start(0, 0, 1'b0);
    wait_main(GATE + 20, "hold0_timeout");
    ro_hold = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start(0, 0, 1'b0);
    wait_main(GATE + 20, "hold1_timeout");

    // 8-bit counter saturates with period 4
    ro_half = 2;
    repeat (5) @(negedge clk);
    @(negedge clk);
    start8 = 1'b1;
    q8.push_back('{cyc + GATE + 3, 255, 255, 1'b1});
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < GATE + 20 && q8.size() != 0; i++) @(negedge clk);
    chk("w8_pending", q8.size(), 32'd0);
    @(negedge clk);
    chk("w8_idle_busy", {31'd0, busy8}, 32'd0);

    // continuous mode, period 16; cont dropped during the third window
    ro_half = 8;
    @(negedge clk);
    cont = 1'b1;
    start = 1'b1;
    c = cyc;
    for (int j = 1; j <= 3; j++) q_main.push_back('{c + j * (GATE + 3), 63, 64, 1'b0});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * (GATE + 3) && q_main.size() > 1; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    cont = 1'b0;
    wait_main(GATE + 20, "cont_timeout");
    @(negedge clk);
    chk("cont_idle_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of GATE
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (501) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_count", {16'd0, count}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    pulse_start(63, 64, 1'b0);
    wait_main(GATE + 20, "postrst_timeout");

    // start re-pulsed in ARM, GATE and DONE: exactly one result
    @(negedge clk);
    start = 1'b1;
    q_main.push_back('{cyc + GATE + 3, 63, 64, 1'b0});
    for (int k = 1; k <= GATE + 3; k++) begin
      @(negedge clk);
      start = (k == 1 || k == 2 || k == 600 || k == GATE + 3);
    end
    @(negedge clk);
    start = 1'b0;
    chk("repulse_idle_busy", {31'd0, busy}, 32'd0);
    repeat (GATE + 10) @(negedge clk);
    chk("repulse_pending", q_main.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
